// File: rtl/dmem_sized_if.sv
// Request/response bus for the byte-addressed data memory.
// The master drives the request fields. The slave returns the ready and response signals.
interface dmem_sized_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_sized.sv
// Synchronous big-endian byte-addressed data memory.
// Supports byte, half and word accesses through a valid/ready request port.
// Configurable wait states. Size, alignment and range errors are reported with the response.
module dmem_sized #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic         clk,
    input logic         rst,
    dmem_sized_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam logic [2:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t              r_state;
    logic                r_ready;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [31:0]         r_rsp_rdata;
    logic [2:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic                r_we;
    logic                r_err;
    logic [7:0]          r_mem [DEPTH];

    logic                w_accept;
    logic                w_req_err;
    logic [ADDR_W-1:0]   w_req_idx;
    logic [ADDR_W-1:0]   w_rd_idx;
    logic [1:0]          w_rd_size;
    logic                w_rd_unsigned;
    logic                w_rd_we;
    logic                w_rd_err;
    logic [7:0]          w_b0;
    logic [7:0]          w_b1;
    logic [7:0]          w_b2;
    logic [7:0]          w_b3;
    logic [31:0]         w_load_data;
    logic [31:0]         w_rsp_rdata;

    assign w_accept  = bus.req_valid && r_ready && !rst;
    assign w_req_idx = bus.req_addr[ADDR_W-1:0];

    // Classify the incoming request: illegal size, misalignment or out-of-range address
    always_comb begin
        w_req_err = 1'b0;
        case (bus.req_size)
            2'b01:   w_req_err = bus.req_addr[0];
            2'b10:   w_req_err = (bus.req_addr[1:0] != 2'b00);
            2'b11:   w_req_err = 1'b1;
            default: w_req_err = 1'b0;
        endcase
        if (bus.req_addr[31:ADDR_W] != '0) begin
            w_req_err = 1'b1;
        end
    end

    // With no wait states the read happens on the accept edge itself, so it uses the live request.
    // Otherwise the read uses the fields latched at accept.
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            w_rd_idx      = w_req_idx;
            w_rd_size     = bus.req_size;
            w_rd_unsigned = bus.req_unsigned;
            w_rd_we       = bus.req_we;
            w_rd_err      = w_req_err;
        end else begin
            w_rd_idx      = r_addr;
            w_rd_size     = r_size;
            w_rd_unsigned = r_unsigned;
            w_rd_we       = r_we;
            w_rd_err      = r_err;
        end
    end

    // Fetch the bytes of the aligned group and assemble the extended load result.
    // Only b0 is used for byte loads, so unaligned byte offsets are harmless for b1..b3.
    always_comb begin
        w_b0 = r_mem[w_rd_idx];
        w_b1 = r_mem[{w_rd_idx[ADDR_W-1:1], 1'b1}];
        w_b2 = r_mem[{w_rd_idx[ADDR_W-1:2], 2'b10}];
        w_b3 = r_mem[{w_rd_idx[ADDR_W-1:2], 2'b11}];
        case (w_rd_size)
            2'b00:   w_load_data = w_rd_unsigned ? {24'h0, w_b0} : {{24{w_b0[7]}}, w_b0};
            2'b01:   w_load_data = w_rd_unsigned ? {16'h0, w_b0, w_b1}
                                                 : {{16{w_b0[7]}}, w_b0, w_b1};
            2'b10:   w_load_data = {w_b0, w_b1, w_b2, w_b3};
            default: w_load_data = '0;
        endcase
        w_rsp_rdata = (w_rd_we || w_rd_err) ? '0 : w_load_data;
    end

    // Commit error-free stores on the accept edge, most significant byte at the lowest address
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_we && !w_req_err) begin
            case (bus.req_size)
                2'b00: begin
                    r_mem[w_req_idx] <= bus.req_wdata[7:0];
                end
                2'b01: begin
                    r_mem[{w_req_idx[ADDR_W-1:1], 1'b0}] <= bus.req_wdata[15:8];
                    r_mem[{w_req_idx[ADDR_W-1:1], 1'b1}] <= bus.req_wdata[7:0];
                end
                2'b10: begin
                    r_mem[{w_req_idx[ADDR_W-1:2], 2'b00}] <= bus.req_wdata[31:24];
                    r_mem[{w_req_idx[ADDR_W-1:2], 2'b01}] <= bus.req_wdata[23:16];
                    r_mem[{w_req_idx[ADDR_W-1:2], 2'b10}] <= bus.req_wdata[15:8];
                    r_mem[{w_req_idx[ADDR_W-1:2], 2'b11}] <= bus.req_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    // Request/response sequencer with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_size      <= '0;
            r_unsigned  <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        r_addr     <= w_req_idx;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_we       <= bus.req_we;
                        r_err      <= w_req_err;
                        if (WAIT_CYCLES > 0) begin
                            r_state     <= S_WAIT;
                            r_cnt       <= WAIT_INIT;
                            r_ready     <= 1'b0;
                            r_rsp_valid <= 1'b0;
                        end else begin
                            r_state     <= S_RESP;
                            r_ready     <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_req_err;
                            r_rsp_rdata <= w_rsp_rdata;
                        end
                    end else begin
                        r_state     <= S_IDLE;
                        r_ready     <= 1'b1;
                        r_rsp_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state     <= S_RESP;
                        r_ready     <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= r_err;
                        r_rsp_rdata <= w_rsp_rdata;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule
